// File: rtl/sdram_axi_pkg.sv
// rtl/sdram_axi_pkg.sv - shared states, response codes and port/grant constants for sdram_axi_arb
package sdram_axi_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    WR   = 3'd3,
    B    = 3'd4
  } state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  localparam int PORT_S00 = 0;
  localparam int PORT_S01 = 1;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_S00  = 2'b01;
  localparam logic [1:0] GRANT_S01  = 2'b10;

endpackage

// File: rtl/sdram_axi_arb_if.sv
// rtl/sdram_axi_arb_if.sv - AXI channel bundle; slave modport faces a requester, master modport faces the SDRAM slave
interface sdram_axi_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [1:0]        awburst;
  logic              wvalid;
  logic              wready;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              wlast;
  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport slave (
    input  awvalid, awaddr, awlen, awburst, wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arlen, arburst, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
  );

  modport master (
    output awvalid, awaddr, awlen, awburst, wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arlen, arburst, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/sdram_axi_arb_sel.sv
// rtl/sdram_axi_arb_sel.sv - combinational grant decision; on contention the port other than i_last_grant wins
module sdram_axi_arb_sel
  import sdram_axi_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic [1:0] i_last_grant,
  output logic [1:0] o_winner
);

  always_comb begin
    o_winner = GRANT_NONE;
    if (i_req == 2'b11) begin
      o_winner = (i_last_grant == GRANT_S00) ? GRANT_S01 : GRANT_S00;
    end else begin
      o_winner = i_req;
    end
  end

endmodule

// File: rtl/sdram_axi_arb.sv
// rtl/sdram_axi_arb.sv - two-port AXI arbiter onto one SDRAM AXI slave, one transaction in flight
// SDRAM_AXI_ARB_RR_EN selects round-robin; otherwise S00 has fixed priority.
module sdram_axi_arb
  import sdram_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARSTN,
  sdram_axi_arb_if.slave        S00_AXI,
  sdram_axi_arb_if.slave        S01_AXI,
  sdram_axi_arb_if.master       M00_AXI,
  output logic [1:0]            grant_o
);

  state_t              r_state, w_state_n;
  logic [1:0]          r_grant, w_grant_n;
  logic                r_aw_done, r_w_done, w_aw_done_n, w_w_done_n;
  logic [1:0]          w_req, w_winner, w_last_grant;
  logic                w_win_aw, w_s01, w_g00, w_g01;
  logic                w_in_ar, w_in_r, w_in_wr, w_in_b;
  logic                w_aw_hs, w_w_last_hs;
  logic [ADDR_W-1:0]   w_awaddr, w_araddr;
  logic [DATA_W-1:0]   w_wdata;
  logic [DATA_W/8-1:0] w_wstrb;

  assign w_req = {S01_AXI.awvalid | S01_AXI.arvalid, S00_AXI.awvalid | S00_AXI.arvalid};

  sdram_axi_arb_sel u_sel (
    .i_req        (w_req),
    .i_last_grant (w_last_grant),
    .o_winner     (w_winner)
  );

`ifdef SDRAM_AXI_ARB_RR_EN
  logic [1:0] r_last_grant;
  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      r_last_grant <= GRANT_S01;
    end else if (r_state == IDLE && |w_req) begin
      r_last_grant <= w_winner;
    end
  end
  assign w_last_grant = r_last_grant;
`else
  // Pinning last_grant to S01 turns the round-robin selector into fixed S00 priority.
  assign w_last_grant = GRANT_S01;
`endif

  assign w_win_aw = w_winner[PORT_S01] ? S01_AXI.awvalid : S00_AXI.awvalid;
  assign w_g00    = r_grant[PORT_S00];
  assign w_g01    = r_grant[PORT_S01];
  assign w_s01    = w_g01;
  assign w_in_ar  = (r_state == AR);
  assign w_in_r   = (r_state == R);
  assign w_in_wr  = (r_state == WR);
  assign w_in_b   = (r_state == B);
  assign grant_o  = r_grant;

  always_ff @(posedge ACLK or negedge ARSTN) begin
    if (!ARSTN) begin
      r_state   <= IDLE;
      r_grant   <= GRANT_NONE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_grant   <= w_grant_n;
      r_aw_done <= w_aw_done_n;
      r_w_done  <= w_w_done_n;
    end
  end

  assign w_aw_hs     = M00_AXI.awvalid & M00_AXI.awready;
  assign w_w_last_hs = M00_AXI.wvalid & M00_AXI.wready & M00_AXI.wlast;

  always_comb begin
    w_state_n   = r_state;
    w_grant_n   = r_grant;
    w_aw_done_n = r_aw_done;
    w_w_done_n  = r_w_done;
    case (r_state)
      IDLE: begin
        if (|w_req) begin
          w_grant_n = w_winner;
          w_state_n = w_win_aw ? WR : AR;
        end
      end
      AR: if (M00_AXI.arvalid && M00_AXI.arready) w_state_n = R;
      R: begin
        if (M00_AXI.rvalid && M00_AXI.rready && M00_AXI.rlast) begin
          w_state_n = IDLE;
          w_grant_n = GRANT_NONE;
        end
      end
      WR: begin
        w_aw_done_n = r_aw_done | w_aw_hs;
        w_w_done_n  = r_w_done | w_w_last_hs;
        if (w_aw_done_n && w_w_done_n) begin
          w_state_n   = B;
          w_aw_done_n = 1'b0;
          w_w_done_n  = 1'b0;
        end
      end
      B: begin
        if (M00_AXI.bvalid && M00_AXI.bready) begin
          w_state_n = IDLE;
          w_grant_n = GRANT_NONE;
        end
      end
      default: begin
        w_state_n = IDLE;
        w_grant_n = GRANT_NONE;
      end
    endcase
  end

  assign w_awaddr = w_s01 ? S01_AXI.awaddr : S00_AXI.awaddr;
  assign w_araddr = w_s01 ? S01_AXI.araddr : S00_AXI.araddr;
  assign w_wdata  = w_s01 ? S01_AXI.wdata  : S00_AXI.wdata;
  assign w_wstrb  = w_s01 ? S01_AXI.wstrb  : S00_AXI.wstrb;

  assign M00_AXI.awvalid = w_in_wr & ~r_aw_done & (w_s01 ? S01_AXI.awvalid : S00_AXI.awvalid);
  assign M00_AXI.awaddr  = w_awaddr;
  assign M00_AXI.awlen   = w_s01 ? S01_AXI.awlen   : S00_AXI.awlen;
  assign M00_AXI.awburst = w_s01 ? S01_AXI.awburst : S00_AXI.awburst;
  assign M00_AXI.wvalid  = w_in_wr & ~r_w_done & (w_s01 ? S01_AXI.wvalid : S00_AXI.wvalid);
  assign M00_AXI.wdata   = w_wdata;
  assign M00_AXI.wstrb   = w_wstrb;
  assign M00_AXI.wlast   = w_s01 ? S01_AXI.wlast : S00_AXI.wlast;
  assign M00_AXI.bready  = w_in_b & (w_s01 ? S01_AXI.bready : S00_AXI.bready);
  assign M00_AXI.arvalid = w_in_ar & (w_s01 ? S01_AXI.arvalid : S00_AXI.arvalid);
  assign M00_AXI.araddr  = w_araddr;
  assign M00_AXI.arlen   = w_s01 ? S01_AXI.arlen   : S00_AXI.arlen;
  assign M00_AXI.arburst = w_s01 ? S01_AXI.arburst : S00_AXI.arburst;
  assign M00_AXI.rready  = w_in_r & (w_s01 ? S01_AXI.rready : S00_AXI.rready);

  // Requester-side returns are gated by both ownership and the phase, so a loser sees all zeros.
  assign S00_AXI.awready = w_g00 & w_in_wr & ~r_aw_done & M00_AXI.awready;
  assign S00_AXI.wready  = w_g00 & w_in_wr & ~r_w_done & M00_AXI.wready;
  assign S00_AXI.bvalid  = w_g00 & w_in_b & M00_AXI.bvalid;
  assign S00_AXI.bresp   = (w_g00 & w_in_b) ? M00_AXI.bresp : AXI_RESP_OKAY;
  assign S00_AXI.arready = w_g00 & w_in_ar & M00_AXI.arready;
  assign S00_AXI.rvalid  = w_g00 & w_in_r & M00_AXI.rvalid;
  assign S00_AXI.rdata   = (w_g00 & w_in_r) ? M00_AXI.rdata : '0;
  assign S00_AXI.rresp   = (w_g00 & w_in_r) ? M00_AXI.rresp : AXI_RESP_OKAY;
  assign S00_AXI.rlast   = w_g00 & w_in_r & M00_AXI.rlast;

  assign S01_AXI.awready = w_g01 & w_in_wr & ~r_aw_done & M00_AXI.awready;
  assign S01_AXI.wready  = w_g01 & w_in_wr & ~r_w_done & M00_AXI.wready;
  assign S01_AXI.bvalid  = w_g01 & w_in_b & M00_AXI.bvalid;
  assign S01_AXI.bresp   = (w_g01 & w_in_b) ? M00_AXI.bresp : AXI_RESP_OKAY;
  assign S01_AXI.arready = w_g01 & w_in_ar & M00_AXI.arready;
  assign S01_AXI.rvalid  = w_g01 & w_in_r & M00_AXI.rvalid;
  assign S01_AXI.rdata   = (w_g01 & w_in_r) ? M00_AXI.rdata : '0;
  assign S01_AXI.rresp   = (w_g01 & w_in_r) ? M00_AXI.rresp : AXI_RESP_OKAY;
  assign S01_AXI.rlast   = w_g01 & w_in_r & M00_AXI.rlast;

endmodule

// File: doc/sdram_axi_arb.md
SDRAM_AXI_ARB -- requirements
Module: sdram_axi_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: AXI address width, all ports.
REQ-002 SHALL have parameter DATA_W, default 32: AXI data width; strobe width DATA_W/8.
REQ-003 SHALL have port ACLK, input, 1: sole clock, rising edge.
REQ-004 SHALL have port ARSTN, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports S00_AXI_* and S01_AXI_*, slave side, one set per requester:
- awvalid, awaddr, awlen[8], awburst[2], wvalid, wdata, wstrb, wlast, bready, arvalid, araddr, arlen[8], arburst[2], rready: inputs.
- awready, wready, bvalid, bresp[2], arready, rvalid, rdata, rresp[2], rlast: outputs.
REQ-006 SHALL have ports M00_AXI_*, master side toward the SDRAM AXI slave: same signal set with directions mirrored.
REQ-007 SHALL have port grant_o, output, 2: one-hot owner of M00 ({S01,S00}); 0 when idle.

Function
REQ-008 SHALL have FSM states IDLE, AR, R, WR, B.
REQ-009 SHALL allow exactly one transaction in flight on M00 at any time.
REQ-010 In IDLE, requesting port = port with awvalid or arvalid high.
- Winner chosen per REQ-024; registered in the same cycle.
- Transition next edge: to WR if winner's awvalid is high, else to AR (write beats read within a port).
REQ-011 In AR, SHALL pass winner's ar* combinationally to M00 and M00 arready back to the winner; go to R on the arvalid&&arready handshake.
REQ-012 In R, SHALL pass r* from M00 to winner and rready from winner to M00; go to IDLE on rvalid&&rready&&rlast.
REQ-013 In WR, SHALL forward aw* and w* channels concurrently; never wait for wvalid before forwarding aw.
REQ-014 In WR, an aw_done flag SHALL be set on the AW handshake; once set, M00 awvalid is forced 0.
REQ-015 In WR, a w_done flag SHALL be set on the W handshake with wlast.
REQ-016 SHALL go from WR to B when both aw_done and w_done are set, or become set in the same cycle; flags clear on entering B.
REQ-017 In B, SHALL pass bvalid/bresp to winner and bready to M00; go to IDLE on the bvalid&&bready handshake.
REQ-018 Non-granted port: all ready/valid outputs 0; rdata, rresp, bresp, rlast 0.
REQ-019 M00 valids SHALL be 0 in IDLE; payloads pass through unmodified (awlen, arlen, awburst, arburst, wstrb), no width conversion.
REQ-020 Arbitration overhead SHALL be exactly 1 cycle: request in IDLE at edge n, M00 valid at cycle n+1; back-to-back transactions therefore spend 1 idle cycle between them.
REQ-021 Request deasserted by its master after winning but before handshake (AXI violation) SHALL NOT be required to be handled; the FSM waits.

Reset
REQ-022 ARSTN low SHALL asynchronously force:
- state=IDLE, aw_done=w_done=0, grant_o=0.
- last_grant=S01, so S00 wins the first contention.
- All ready/valid outputs 0.
REQ-023 Reset mid-burst SHALL abort without completing beats; the first post-reset transaction SHALL start cleanly from IDLE.

Configuration
REQ-024 SHALL use macro SDRAM_AXI_ARB_RR_EN:
- Defined: round-robin; on contention, the port not equal to last_grant wins; last_grant updates at each IDLE grant.
- Undefined: fixed priority; S00 always wins contention; last_grant register omitted.

Structure
REQ-025 SHALL place the state enum (IDLE/AR/R/WR/B), the AXI resp constants (OKAY=2'b00) and the port index constants in shared package sdram_axi_pkg.
REQ-026 SHALL implement the grant decision as sub-module sdram_axi_arb_sel: combinational, inputs req[1:0] and last_grant, output one-hot winner.

Verification
REQ-027 Single read: S00 arvalid, araddr=0x100, arlen=3 -> M00 arvalid cycle+1; 4 R beats to S00, rlast on beat 4; grant_o=2'b01 throughout; back to IDLE.
REQ-028 Write with W before AW: S01 asserts wvalid 3 cycles before awvalid, awaddr=0x200, awlen=1, wstrb=4'hF -> 2 beats forwarded, B OKAY to S01 only; S00 sees bvalid=0.
REQ-029 Contention, RR_EN defined: both ports request reads every cycle, 8 transactions -> grants alternate S00,S01,S00,...; 4 each.
REQ-030 Contention, RR_EN undefined: same stimulus -> all 8 grants to S00 while S00 keeps requesting.
REQ-031 Same-port AW+AR: S00 awvalid and arvalid together -> write (WR,B) completes before AR is forwarded.
REQ-032 Reset mid-burst: ARSTN low during beat 2 of an arlen=7 read -> outputs 0 immediately; after release, S01 read of arlen=0 completes normally.
